// File: rtl/lfsr_noise_pkg.sv
// Shared constants, FSM state type and seed helper for the lfsr_noise_gen noise source.
package lfsr_noise_pkg;

  localparam int unsigned LFSR_W = 32;

  // Taps of x^32 + x^22 + x^2 + x + 1, expressed as state bit indices
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOAD
  } state_t;

  // The all-zero state would lock the LFSR, so it is replaced by 1
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/lfsr_cell.sv
// One 32-bit Fibonacci LFSR channel: shifts on tick, loads on load, exposes bit 31.
module lfsr_cell
  import lfsr_noise_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 32'h1
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic              msb
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  assign fb  = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  assign msb = s[LFSR_W-1];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s <= RESET_SEED;
    end else if (load) begin
      s <= load_val;
    end else if (tick) begin
      s <= {s[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_noise_gen.sv
// NCH-channel LFSR noise generator with prescaler, run-time reseed handshake and pause.
// Optional popcount output on `sum` when LFSR_NOISE_SUM_EN is defined.
module lfsr_noise_gen
  import lfsr_noise_pkg::*;
#(
  parameter int unsigned       NCH       = 16,
  parameter int unsigned       DIV_W     = 16,
  parameter logic [LFSR_W-1:0] SEED_BASE = 32'hACE1_2023,
  parameter logic [LFSR_W-1:0] SEED_STEP = 32'h9E37_79B9
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  output logic [NCH-1:0]    dac,
  output logic              step
`ifdef LFSR_NOISE_SUM_EN
  ,
  output logic [$clog2(NCH+1)-1:0] sum
`endif
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state, state_next;
  logic [DIV_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [LFSR_W-1:0] seed_acc;
  logic [LFSR_W-1:0] load_val;
  logic [NCH-1:0]    bits;
  logic              tick;
  logic              accept;
  logic              last_load;

  assign seed_ready = (state != LOAD);
  assign accept     = seed_valid && seed_ready;
  // >= rather than == so that lowering div below cnt ticks on the next RUN cycle
  assign tick       = (state == RUN) && (cnt >= div);
  assign last_load  = (state == LOAD) && (idx == IDX_W'(NCH - 1));
  assign load_val   = seed_fix(seed_acc);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept)  state_next = LOAD;
        else if (en) state_next = RUN;
      end
      RUN: begin
        if (accept)   state_next = LOAD;
        else if (!en) state_next = IDLE;
      end
      LOAD: begin
        if (last_load) state_next = en ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One shared adder walks base, base+STEP, ... while idx selects the channel being written
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      seed_acc <= '0;
    end else if (accept) begin
      cnt      <= '0;
      idx      <= '0;
      seed_acc <= seed_data;
    end else if (state == LOAD) begin
      cnt      <= '0;
      idx      <= idx + IDX_W'(1);
      seed_acc <= seed_acc + SEED_STEP;
    end else if (state == RUN) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [LFSR_W-1:0] CH_SEED = seed_fix(SEED_BASE + SEED_STEP * LFSR_W'(k));

    lfsr_cell #(
      .RESET_SEED(CH_SEED)
    ) u_cell (
      .sclk    (sclk),
      .rst_n   (rst_n),
      .tick    (tick),
      .load    ((state == LOAD) && (idx == IDX_W'(k))),
      .load_val(load_val),
      .msb     (bits[k])
    );
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      dac  <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) dac <= bits;
    end
  end

`ifdef LFSR_NOISE_SUM_EN
  localparam int unsigned SUM_W = $clog2(NCH + 1);

  logic [SUM_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pop = pop + SUM_W'(dac[i]);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= pop;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Self-checking bench for lfsr_noise_gen: per-cycle reference model, seed table, corner sequences.
module tb_lfsr_noise_gen;

  localparam int          NCH   = 16;
  localparam int          DIV_W = 16;
  localparam logic [31:0] SB    = 32'hACE1_2023;
  localparam logic [31:0] SS    = 32'h9E37_79B9;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  logic             sclk;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             seed_valid;
  logic [31:0]      seed_data;
  logic             seed_ready;
  logic [NCH-1:0]   dac;
  logic             step;
`ifdef LFSR_NOISE_SUM_EN
  logic [$clog2(NCH+1)-1:0] sum;
`endif

  lfsr_noise_gen #(
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .SEED_BASE(SB),
    .SEED_STEP(SS)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .en        (en),
    .div       (div),
    .seed_valid(seed_valid),
    .seed_data (seed_data),
    .seed_ready(seed_ready),
    .dac       (dac),
    .step      (step)
`ifdef LFSR_NOISE_SUM_EN
    ,
    .sum       (sum)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: channel states as plain words, mode as 0=idle 1=run 2=load
  logic [31:0]    mst[NCH];
  logic [NCH-1:0] mdac;
  logic           mstep;
  int             msum, mmode, mleft, mcnt;

  function automatic logic [31:0] fix(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] s);
    return {s[30:0], ^(s & TAPS)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) mst[k] = fix(SB + SS * 32'(k));
    mdac = '0; mstep = 0; msum = 0; mmode = 0; mleft = 0; mcnt = 0;
  endtask

  task automatic model_edge();
    bit tk, acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk    = (mmode == 1) && (mcnt >= int'(div));
    acc   = seed_valid && (mmode != 2);
    msum  = $countones(mdac);
    mstep = tk;
    if (tk) begin
      for (int k = 0; k < NCH; k++) begin
        mdac[k] = mst[k][31];
        mst[k]  = adv(mst[k]);
      end
    end
    if (acc) begin
      for (int k = 0; k < NCH; k++) mst[k] = fix(seed_data + SS * 32'(k));
      mmode = 2; mleft = NCH; mcnt = 0;
    end else if (mmode == 2) begin
      mcnt = 0;
      mleft--;
      if (mleft == 0) mmode = en ? 1 : 0;
    end else begin
      if (mmode == 1) mcnt = tk ? 0 : mcnt + 1;
      mmode = en ? 1 : 0;
    end
  endtask

  task automatic check_outputs();
    chk("dac", 64'(dac), 64'(mdac));
    chk("step", 64'(step), 64'(mstep));
    chk("seed_ready", 64'(seed_ready), 64'(mmode != 2));
`ifdef LFSR_NOISE_SUM_EN
    chk("sum", 64'(sum), 64'(msum));
`endif
  endtask

  task automatic cycle();
    @(posedge sclk);
    model_edge();
    @(negedge sclk);
    check_outputs();
  endtask

  // Issue a load, then count cycles until seed_ready returns and steps seen meanwhile
  task automatic do_load(input logic [31:0] sd, output int low, output int steps_in);
    int g;
    seed_valid = 1'b1; seed_data = sd;
    cycle();
    seed_valid = 1'b0;
    low = 1; steps_in = 0; g = 0;
    while (!seed_ready && g < 50) begin
      cycle(); g++;
      if (!seed_ready) low++;
      if (step) steps_in++;
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    int          first;
    int          second;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low, sin, n, f1, f2, g, gap;
    logic [NCH-1:0] held;

    tbl[0] = '{32'h8000_0000, 1, 33};
    tbl[1] = '{32'h4000_0000, 2, 34};
    tbl[2] = '{32'hFFFF_FFFF, 1, 2};
    tbl[3] = '{32'h0000_0000, 32, 0};
    tbl[4] = '{32'h0000_0002, 31, 0};
    tbl[5] = '{32'h0001_0000, 16, 0};

    rst_n = 1'b0; en = 1'b0; div = '0; seed_valid = 1'b0; seed_data = '0;
    model_reset();
    repeat (2) @(negedge sclk);
    check_outputs();
    rst_n = 1'b1;
    repeat (3) cycle();

    // en rising: RUN next cycle, first step the cycle after
    en = 1'b1;
    cycle();
    chk("en_first_cycle_step", 64'(step), 64'd0);
    cycle();
    chk("en_second_cycle_step", 64'(step), 64'd1);
    repeat (5) cycle();

    // Seed table: load length, steps inside load, step index of first/second one on dac[0]
    for (int r = 0; r < 6; r++) begin
      do_load(tbl[r].seed, low, sin);
      chk("load_ready_low_cycles", 64'(low), 64'(NCH));
      chk("load_steps_inside", 64'(sin), 64'd0);
      n = 0; f1 = 0; f2 = 0; g = 0;
      while (g < 200 && !(f2 != 0 || (tbl[r].second == 0 && f1 != 0))) begin
        cycle(); g++;
        if (step) begin
          n++;
          if (dac[0]) begin
            if (f1 == 0) f1 = n;
            else if (f2 == 0) f2 = n;
          end
        end
      end
      chk("ch0_first_one_step", 64'(f1), 64'(tbl[r].first));
      if (tbl[r].second != 0) chk("ch0_second_one_step", 64'(f2), 64'(tbl[r].second));
    end

    // Prescaler spacing with div=3
    div = DIV_W'(3);
    g = 0;
    while (!step && g < 20) begin cycle(); g++; end
    gap = 0;
    do begin cycle(); gap++; end while (!step && gap < 20);
    chk("div3_step_gap", 64'(gap), 64'd4);

    // Lower div below cnt mid-count: tick on the next cycle, then period 2
    g = 0;
    while (mcnt != 2 && g < 20) begin cycle(); g++; end
    chk("reached_cnt2", 64'(mcnt), 64'd2);
    div = DIV_W'(1);
    cycle();
    chk("div_lowered_step", 64'(step), 64'd1);
    cycle();
    chk("div1_gap_a", 64'(step), 64'd0);
    cycle();
    chk("div1_gap_b", 64'(step), 64'd1);

    // Pause right after a step: no steps, dac frozen
    en = 1'b0;
    held = dac;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("pause_step", 64'(step), 64'd0);
      chk("pause_dac", 64'(dac), 64'(held));
    end
    en = 1'b1;
    repeat (6) cycle();

    // seed_valid in a tick cycle: that tick completes, then a clean load
    div = DIV_W'(3);
    g = 0;
    while (!(mmode == 1 && mcnt >= 3) && g < 20) begin cycle(); g++; end
    held = dac;
    seed_valid = 1'b1; seed_data = 32'h1234_5678;
    cycle();
    seed_valid = 1'b0;
    chk("tick_with_load_step", 64'(step), 64'd1);
    chk("tick_with_load_ready", 64'(seed_ready), 64'd0);
    g = 0; low = 1; sin = 0;
    while (!seed_ready && g < 50) begin
      cycle(); g++;
      if (!seed_ready) low++;
      if (step) sin++;
    end
    chk("tick_load_len", 64'(low), 64'(NCH));
    chk("tick_load_steps", 64'(sin), 64'd0);
    repeat (20) cycle();

    // Asynchronous reset in the middle of a load
    seed_valid = 1'b1; seed_data = 32'hDEAD_BEEF;
    cycle();
    seed_valid = 1'b0;
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dac", 64'(dac), 64'd0);
    chk("async_rst_step", 64'(step), 64'd0);
    chk("async_rst_ready", 64'(seed_ready), 64'd1);
`ifdef LFSR_NOISE_SUM_EN
    chk("async_rst_sum", 64'(sum), 64'd0);
`endif
    model_reset();
    cycle();
    rst_n = 1'b1; div = '0; en = 1'b1;
    repeat (40) cycle();

    // Slowest rate: no step within a short window
    div = '1;
    repeat (60) cycle();
    div = '0;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      seed_valid = ($urandom_range(0, 59) == 0);
      seed_data  = $urandom;
      if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 4));
      cycle();
    end
    seed_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lfsr_noise_gen.md
# lfsr_noise_gen

Parametrised successor of the 16-bit WNG240 LFSR noise source. It runs NCH independent maximal-length 32-bit LFSRs, one per DAC bit, and drives the external equal-resistor summing network. The update rate is programmable through a prescaler, all channels can be reseeded at run time through a valid/ready handshake, and the generator can be paused. An optional on-chip population-count sum gives the bench and the system a digital image of the analogue noise level.

## Interface
- NCH, 16, number of noise channels / DAC bits (1..64)
- DIV_W, 16, prescaler divider width
- SEED_BASE, 32'hACE1_2023, channel-0 reset seed
- SEED_STEP, 32'h9E37_79B9, per-channel seed increment (mod 2^32)

- sclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low pauses stepping
- div  in  DIV_W  step every div+1 enabled cycles
- seed_valid  in  1  seed load request
- seed_data  in  32  base seed for load
- seed_ready  out  1  load accepted when high with seed_valid
- dac  out  NCH  one noise bit per channel, registered
- step  out  1  one-cycle pulse, high in the cycle dac updates
- sum  out  $clog2(NCH+1)  popcount of dac (LFSR_NOISE_SUM_EN only)

## Operation
- Each channel is a Fibonacci LFSR with polynomial x^32+x^22+x^2+x+1 (maximal length).
- On tick: fb = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], fb}; dac[k] <= s_k[31] (pre-shift value).
- Seed of channel k = base + k*SEED_STEP mod 2^32. A computed seed of 0 is replaced by 32'h1, so the all-zero lockup state is unreachable.
- Reset seeds use base = SEED_BASE.
- FSM states:
  - IDLE: en=0.
  - RUN: en=1.
  - LOAD: reseeding in progress.
- FSM transitions:
  - IDLE→RUN when en=1. RUN→IDLE when en=0.
  - IDLE or RUN → LOAD on seed_valid & seed_ready. seed_data is captured as base.
  - LOAD writes channel i in load cycle i (i=0..NCH-1) using a single shared running adder. It lasts exactly NCH cycles, then goes to RUN if en, else IDLE.
- seed_ready = 1 in IDLE and RUN, 0 in LOAD.
- Prescaler counter cnt:
  - Increments only in RUN.
  - tick = RUN & (cnt >= div). On tick cnt <= 0, otherwise cnt+1.
  - The >= comparison covers div being lowered below cnt mid-count: tick on the next RUN cycle.
  - cnt holds in IDLE and clears on entering LOAD.
- No ticks during LOAD. dac holds its last value until the first tick after LOAD.
- A seed_valid in the same cycle as a tick: the tick completes in that cycle, then LOAD starts.
- Reset mid-LOAD: all channels return to the reset seeds, FSM returns to IDLE.

## Timing
- Reset values: dac=0, step=0, sum=0, seed_ready=1, cnt=0, FSM=IDLE, channel states = reset seeds.
- en rising at cycle t: FSM=RUN at t+1. With div=0, step and a new dac appear at t+2 and every cycle after.
- Step period = div+1 sclk cycles. div = 2^DIV_W−1 is the slowest rate.
- Load handshake: accepted at edge t, seed_ready low for cycles t+1..t+NCH, high again at t+NCH+1.
- sum is registered one cycle after dac (latency 1). It is not a combinational output.

## Configuration
- LFSR_NOISE_SUM_EN defined: a sum output and a popcount adder tree plus register are present.
- LFSR_NOISE_SUM_EN undefined: the sum port and its logic are absent. All other behaviour is identical.

## Structure
- Package lfsr_noise_pkg holds:
  - LFSR_W=32
  - tap constants 31, 21, 1, 0
  - FSM state typedef {IDLE, RUN, LOAD}
  - function seed_fix (zero→1)
- Sub-module lfsr_cell:
  - one 32-bit LFSR with tick input, load input and load value
  - outputs the current bit [31]
  - instantiated NCH times by a generate loop
- Top holds the FSM, prescaler, seed adder, dac/step registers and the optional sum.

## Test plan
- Reset: assert rst_n=0 mid-run → dac=0, step=0, seed_ready=1, sum=0 immediately (asynchronous).
- Load seed_data=32'h8000_0000, NCH=16, div=0, en=1 → seed_ready low for exactly 16 cycles. First step gives dac[0]=1, then dac[0]=0 for the next 31 steps (single bit shifted through).
- Load seed_data=0 → channel 0 seeded 32'h1, never stalls: dac[0] reaches 1 on step 32.
- div=3: step spacing 4 cycles. Change div 3→1 when cnt=2: step on the next cycle, then every 2 cycles. en=0 for 5 cycles: no step, dac frozen.
- seed_valid in the same cycle as a tick: dac updates once, LOAD lasts NCH cycles, and no step occurs inside LOAD.
- With LFSR_NOISE_SUM_EN, NCH=16, div=0, 500000 steps: the histogram of sum matches binomial(16, 0.5) within 2% per bin for sum=4..12 (sum=8 ≈ 98190), and the mean is 8.00±0.01.
